skp_compensation_ctrl: RTL and testbench
========================================

# skp_compensation_ctrl

Read-side clock-compensation controller for the RX elastic buffer. It sequences the buffer's read enable, waits for the nominal fill level before releasing data, and adjusts the recovered 10b symbol stream at SKP ordered sets. When the buffer runs low it duplicates one SKP; when it runs high it drops one. It sits between the elastic buffer read port and the 8b/10b decoder, in the `read_clk` domain.

## Interface
- `DATA_WIDTH`, 10: symbol width.
- `BUFFER_DEPTH`, 16: elastic buffer depth. Power of 2.
- `MARGIN`, 2: hysteresis around the nominal fill level, in symbols. Must be ≥1 and ≤ `BUFFER_DEPTH/2`.
- `COM_N`/`COM_P`, 10'b0011111010 / 10'b1100000101: K28.5 symbol, RD-/RD+.
- `SKP_N`/`SKP_P`, 10'b0011110100 / 10'b1100001011: K28.0 symbol, RD-/RD+.
- `read_clk`, in, 1: the block's only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `buffer_mode`, in, 1: 0 = nominal half-full, 1 = nominal empty. Quasi-static.
- `fill_level`, in, $clog2(BUFFER_DEPTH)+1: buffer occupancy, already synchronized into `read_clk`.
- `underflow`, in, 1: buffer empty flag.
- `overflow`, in, 1: buffer full flag, synchronized into `read_clk`.
- `data_in`, in, `DATA_WIDTH`: buffer read data. Valid the cycle after `read_enable` was high.
- `read_enable`, out, 1: buffer read strobe.
- `data_out`, out, `DATA_WIDTH`: compensated symbol stream, registered.
- `data_valid`, out, 1: qualifies `data_out`.
- `skp_added`, out, 1: one-cycle pulse when a SKP is duplicated.
- `skp_removed`, out, 1: one-cycle pulse when a SKP is dropped.
- `overflow_err`, out, 1: sticky; cleared only by reset.
- `locked`, out, 1: high while in RUN.

## Operation
- Thresholds:
  - `nominal` = `BUFFER_DEPTH/2` when `buffer_mode`=0, else `MARGIN`.
  - `lo` = `nominal` − `MARGIN`; `hi` = `nominal` + `MARGIN`.
  - All comparisons are unsigned, at `fill_level` width.
- States:
  - FILL (reset state): `read_enable`=0. Go to RUN when `fill_level` ≥ `nominal` and `underflow`=0.
  - RUN: `read_enable`=1 except in an insert cycle. Go to FILL in the same cycle `underflow`=1; `read_enable` is forced 0 that cycle.
- Pipeline:
  - `rd_vld` is `read_enable` delayed by one cycle.
  - Each cycle `rd_vld`=1, `data_out`/`data_valid` load `data_in`/1 on the next edge, unless the word is removed.
- Ordered-set tracking:
  - `in_os` sets on a valid COM (either disparity) and clears on any valid symbol other than SKP.
  - `acted` clears on COM and sets on any add or remove.
  - The candidate is the first valid SKP after a COM (`in_os`=1, `acted`=0, previous valid symbol was COM).
- Insert: a candidate with `fill_level` < `lo`.
  - `read_enable` is combinationally 0 in that cycle.
  - The next cycle, `data_out` holds the SKP with `data_valid`=1, which duplicates it.
  - `skp_added` pulses on the edge that loads the duplicate.
- Remove: a candidate with `fill_level` > `hi`.
  - The word is not loaded; `data_valid`=0 for one cycle.
  - `skp_removed` pulses on that same edge.
- At most one add or remove per ordered set. Insert wins if both conditions somehow hold.
- In mode 1, `lo`=0, so insert never fires.
- `overflow`=1 sets `overflow_err`. It has no effect on state.

## Timing
- All outputs reset to 0; state resets to FILL. Reset asserted mid-stream takes effect immediately, with no partial OS carried over.
- FILL→RUN: `read_enable` rises 1 cycle after the threshold is met. First `data_valid` follows 2 cycles after that.
- Steady latency: 1 cycle from `data_in` to `data_out`.
- Insert sequence:
  - t: SKP arrives; `read_enable`=0.
  - t+1: `data_out`=SKP.
  - t+2: `data_out`=SKP (duplicate).
  - t+3: next symbol. No bubble in the stream.
- Remove sequence:
  - t: SKP arrives.
  - t+1: `data_valid`=0.
  - t+2: next symbol.
- Underflow in RUN: `data_valid` drops after the last in-flight word; `locked` falls on the next edge.
- Simultaneous `underflow` and candidate SKP: underflow takes priority and no action is taken.

## Test plan
- Reset, then `buffer_mode`=0 with `fill_level` ramping 0→8 → `read_enable` rises the cycle after `fill_level`=8, `locked`=1, first `data_valid` 2 cycles later.
- `fill_level`=5, stream COM,SKP,SKP,SKP,D → output COM,SKP,SKP,SKP,SKP,D with no gaps; one `skp_added`.
- `fill_level`=11, same stream → output COM,SKP,SKP,D; one cycle with `data_valid`=0; one `skp_removed`.
- `fill_level` held at 5 across two consecutive OSes → exactly one insert per OS; none on SKPs not preceded by COM.
- `buffer_mode`=1 with `fill_level`=0 at a SKP → no insert. `fill_level`=5 at a SKP → remove.
- `underflow` pulse in RUN → FILL; `locked`=0, `read_enable`=0 until refill. Pulse `overflow` → `overflow_err` stays 1 until `rst_n` is asserted.

Source files
------------

// File: rtl/skp_compensation_ctrl_if.sv
// Elastic-buffer read port and compensated-stream bundle for skp_compensation_ctrl.
// master = the controller, slave = buffer/decoder side (or a testbench).
interface skp_compensation_ctrl_if #(
  parameter int DATA_WIDTH = 10,
  parameter int FILL_W     = 5
);
  logic                  buffer_mode;
  logic [FILL_W-1:0]     fill_level;
  logic                  underflow;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  skp_added;
  logic                  skp_removed;
  logic                  overflow_err;
  logic                  locked;

  modport master (
    input  buffer_mode, fill_level, underflow, overflow, data_in,
    output read_enable, data_out, data_valid, skp_added, skp_removed,
           overflow_err, locked
  );

  modport slave (
    output buffer_mode, fill_level, underflow, overflow, data_in,
    input  read_enable, data_out, data_valid, skp_added, skp_removed,
           overflow_err, locked
  );
endinterface

// File: rtl/skp_compensation_ctrl.sv
// Read-side clock compensation for the RX elastic buffer. Holds off reads
// until the nominal fill is reached, then duplicates or drops the first SKP
// of an ordered set to pull the fill level back into the hysteresis window.
module skp_compensation_ctrl #(
  parameter int                    DATA_WIDTH   = 10,
  parameter int                    BUFFER_DEPTH = 16,
  parameter int                    MARGIN       = 2,
  parameter logic [DATA_WIDTH-1:0] COM_N        = 10'b0011111010,
  parameter logic [DATA_WIDTH-1:0] COM_P        = 10'b1100000101,
  parameter logic [DATA_WIDTH-1:0] SKP_N        = 10'b0011110100,
  parameter logic [DATA_WIDTH-1:0] SKP_P        = 10'b1100001011
) (
  input logic                      read_clk,
  input logic                      rst_n,
  skp_compensation_ctrl_if.master  bus
);

  localparam int                FILL_W = $clog2(BUFFER_DEPTH) + 1;
  localparam logic [FILL_W-1:0] HALF   = FILL_W'(BUFFER_DEPTH / 2);
  localparam logic [FILL_W-1:0] MARG   = FILL_W'(MARGIN);

  typedef enum logic {FILL, RUN} state_e;

  state_e                state_q, state_d;
  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  skp_added_q, skp_added_d;
  logic                  skp_removed_q, skp_removed_d;
  logic                  overflow_err_q, overflow_err_d;
  logic                  in_os_q, in_os_d;
  logic                  acted_q, acted_d;
  logic                  prev_com_q, prev_com_d;
  logic                  ins_pend_q, ins_pend_d;

  logic [FILL_W-1:0]     nominal, lo, hi;
  logic                  is_com, is_skp, cand, ins, rem, read_enable;

  // Fill thresholds and symbol classification of the word now on data_in.
  always_comb begin
    nominal = bus.buffer_mode ? MARG : HALF;
    lo      = nominal - MARG;
    hi      = nominal + MARG;
    is_com  = (bus.data_in == COM_N) || (bus.data_in == COM_P);
    is_skp  = (bus.data_in == SKP_N) || (bus.data_in == SKP_P);
    // Only the first SKP right after a COM may be acted on; underflow
    // suppresses any adjustment in the cycle it is seen.
    cand    = rd_vld_q && is_skp && in_os_q && !acted_q && prev_com_q &&
              (state_q == RUN) && !bus.underflow;
    ins     = cand && (bus.fill_level < lo);
    rem     = cand && !ins && (bus.fill_level > hi);
  end

  // FILL/RUN next state and the buffer read strobe.
  always_comb begin
    state_d     = state_q;
    read_enable = 1'b0;
    case (state_q)
      FILL: begin
        if ((bus.fill_level >= nominal) && !bus.underflow) state_d = RUN;
      end
      RUN: begin
        if (bus.underflow) state_d = FILL;
        else               read_enable = !ins;
      end
      default: state_d = FILL;
    endcase
  end

  // Output stage: normal load, duplicate of a held SKP, or a dropped word.
  always_comb begin
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    skp_added_d    = 1'b0;
    skp_removed_d  = 1'b0;
    ins_pend_d     = ins;
    overflow_err_d = overflow_err_q | bus.overflow;
    if (ins_pend_q) begin
      // Read was stalled last cycle, so data_out still holds the SKP.
      data_valid_d = 1'b1;
      skp_added_d  = 1'b1;
    end else if (rd_vld_q) begin
      if (rem) begin
        skp_removed_d = 1'b1;
      end else begin
        data_out_d   = bus.data_in;
        data_valid_d = 1'b1;
      end
    end
  end

  // Ordered-set tracking over words actually read from the buffer.
  always_comb begin
    in_os_d    = in_os_q;
    acted_d    = acted_q;
    prev_com_d = prev_com_q;
    if (rd_vld_q) begin
      if (is_com) begin
        in_os_d    = 1'b1;
        acted_d    = 1'b0;
        prev_com_d = 1'b1;
      end else begin
        prev_com_d = 1'b0;
        if (!is_skp) in_os_d = 1'b0;
      end
    end
    if (ins || rem) acted_d = 1'b1;
  end

  // State and pipeline registers; reset drops any partial ordered set.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FILL;
      rd_vld_q       <= 1'b0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      skp_added_q    <= 1'b0;
      skp_removed_q  <= 1'b0;
      overflow_err_q <= 1'b0;
      in_os_q        <= 1'b0;
      acted_q        <= 1'b0;
      prev_com_q     <= 1'b0;
      ins_pend_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_vld_q       <= read_enable;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      skp_added_q    <= skp_added_d;
      skp_removed_q  <= skp_removed_d;
      overflow_err_q <= overflow_err_d;
      in_os_q        <= in_os_d;
      acted_q        <= acted_d;
      prev_com_q     <= prev_com_d;
      ins_pend_q     <= ins_pend_d;
    end
  end

  assign bus.read_enable  = read_enable;
  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.skp_added    = skp_added_q;
  assign bus.skp_removed  = skp_removed_q;
  assign bus.overflow_err = overflow_err_q;
  assign bus.locked       = (state_q == RUN);

endmodule

// File: tb/tb_skp_compensation_ctrl.sv
// Directed bench for skp_compensation_ctrl with a simple elastic-buffer model.
module tb_skp_compensation_ctrl;

  localparam logic [9:0] COM_N  = 10'b0011111010;
  localparam logic [9:0] COM_P  = 10'b1100000101;
  localparam logic [9:0] SKP_N  = 10'b0011110100;
  localparam logic [9:0] SKP_P  = 10'b1100001011;
  localparam logic [9:0] FILL_D = 10'h155;
  localparam logic [9:0] IDLE_D = 10'h3FF;
  localparam logic [9:0] D1     = 10'h0A3;
  localparam logic [9:0] D2     = 10'h0B6;
  localparam logic [9:0] D3     = 10'h0C9;
  localparam logic [9:0] D4     = 10'h0DC;

  logic read_clk;
  logic rst_n;

  skp_compensation_ctrl_if #(.DATA_WIDTH(10), .FILL_W(5)) bus ();

  skp_compensation_ctrl dut (
    .read_clk (read_clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial begin
    read_clk = 1'b0;
    forever #5 read_clk = ~read_clk;
  end

  int         total = 0;
  int         bad   = 0;
  int         n_add = 0;
  int         n_rem = 0;
  bit         re_s  = 0;
  logic [9:0] src_q [$];
  bit         ob_v  [$];
  logic [9:0] ob_d  [$];

  // One cycle of the buffer model: a read strobe seen this cycle presents
  // the next word just after the edge; outputs recorded 2 time units later.
  task automatic tick();
    @(negedge read_clk);
    re_s = bus.read_enable;
    @(posedge read_clk);
    #1;
    if (re_s) bus.data_in = (src_q.size() > 0) ? src_q.pop_front() : FILL_D;
    else      bus.data_in = IDLE_D;
    #1;
    ob_v.push_back(bus.data_valid);
    ob_d.push_back(bus.data_out);
    if (bus.skp_added)   n_add++;
    if (bus.skp_removed) n_rem++;
  endtask

  task automatic clear_obs();
    ob_v.delete();
    ob_d.delete();
    n_add = 0;
    n_rem = 0;
  endtask

  function automatic int find_com();
    for (int i = 0; i < ob_v.size(); i++)
      if (ob_v[i] && (ob_d[i] == COM_N || ob_d[i] == COM_P)) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.buffer_mode = 1'b0;
    bus.fill_level  = '0;
    bus.underflow   = 1'b0;
    bus.overflow    = 1'b0;
    bus.data_in     = IDLE_D;
    #3;
    total++;
    if ({bus.read_enable, bus.data_valid, bus.skp_added, bus.skp_removed,
         bus.overflow_err, bus.locked} !== 6'b0 || bus.data_out !== 10'h0) begin
      bad++;
      $display("FAIL reset_outputs: got re/dv/add/rem/err/lock=%b%b%b%b%b%b dout=%h, expected all 0",
               bus.read_enable, bus.data_valid, bus.skp_added, bus.skp_removed,
               bus.overflow_err, bus.locked, bus.data_out);
    end
    #9 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int k = 0; k <= 8; k++) begin
      bus.fill_level = 5'(k);
      #1;
      total++;
      if (bus.read_enable !== 1'b0 || bus.locked !== 1'b0) begin
        bad++;
        $display("FAIL fill_hold_%0d: got re=%b locked=%b, expected 0 0", k, bus.read_enable, bus.locked);
      end
      tick();
    end
    total++;
    if (bus.read_enable !== 1'b1 || bus.locked !== 1'b1 || bus.data_valid !== 1'b0) begin
      bad++;
      $display("FAIL fill_lock: got re=%b locked=%b dv=%b, expected 1 1 0",
               bus.read_enable, bus.locked, bus.data_valid);
    end
    tick();
    total++;
    if (bus.data_valid !== 1'b0) begin
      bad++;
      $display("FAIL fill_dv_early: got dv=%b, expected 0", bus.data_valid);
    end
    tick();
    total++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== FILL_D) begin
      bad++;
      $display("FAIL fill_first_dv: got dv=%b dout=%h, expected 1 %h", bus.data_valid, bus.data_out, FILL_D);
    end
  endtask

  task automatic test_insert();
    logic [10:0] exp [6];
    int idx;
    exp = '{{1'b1, COM_N}, {1'b1, SKP_N}, {1'b1, SKP_N}, {1'b1, SKP_N}, {1'b1, SKP_N}, {1'b1, D1}};
    bus.fill_level = 5'd5;
    clear_obs();
    src_q = '{COM_N, SKP_N, SKP_N, SKP_N, D1};
    repeat (14) tick();
    idx = find_com();
    total++;
    if (idx < 0 || idx + 6 > ob_v.size()) begin
      bad++;
      $display("FAIL ins_align: got com index %0d, expected a COM with 6 words after it", idx);
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (ob_v[idx+i] !== exp[i][10] || (exp[i][10] && ob_d[idx+i] !== exp[i][9:0])) begin
          bad++;
          $display("FAIL ins_word_%0d: got v=%b d=%h, expected v=%b d=%h", i, ob_v[idx+i], ob_d[idx+i],
                   exp[i][10], exp[i][9:0]);
        end
      end
    end
    total++;
    if (n_add !== 1 || n_rem !== 0) begin
      bad++;
      $display("FAIL ins_pulses: got add=%0d rem=%0d, expected 1 0", n_add, n_rem);
    end
    bus.fill_level = 5'd8;
  endtask

  task automatic test_remove();
    logic [10:0] exp [5];
    int idx;
    exp = '{{1'b1, COM_P}, {1'b0, 10'h0}, {1'b1, SKP_P}, {1'b1, SKP_P}, {1'b1, D1}};
    bus.fill_level = 5'd11;
    clear_obs();
    src_q = '{COM_P, SKP_P, SKP_P, SKP_P, D1};
    repeat (14) tick();
    idx = find_com();
    total++;
    if (idx < 0 || idx + 5 > ob_v.size()) begin
      bad++;
      $display("FAIL rem_align: got com index %0d, expected a COM with 5 words after it", idx);
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (ob_v[idx+i] !== exp[i][10] || (exp[i][10] && ob_d[idx+i] !== exp[i][9:0])) begin
          bad++;
          $display("FAIL rem_word_%0d: got v=%b d=%h, expected v=%b d=%h", i, ob_v[idx+i], ob_d[idx+i],
                   exp[i][10], exp[i][9:0]);
        end
      end
    end
    total++;
    if (n_add !== 0 || n_rem !== 1) begin
      bad++;
      $display("FAIL rem_pulses: got add=%0d rem=%0d, expected 0 1", n_add, n_rem);
    end
    bus.fill_level = 5'd8;
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp [10];
    int idx;
    exp = '{{1'b1, COM_N}, {1'b1, SKP_N}, {1'b1, SKP_N}, {1'b1, D2}, {1'b1, SKP_N},
            {1'b1, D3}, {1'b1, COM_P}, {1'b1, SKP_P}, {1'b1, SKP_P}, {1'b1, D4}};
    bus.fill_level = 5'd5;
    clear_obs();
    src_q = '{COM_N, SKP_N, D2, SKP_N, D3, COM_P, SKP_P, D4};
    repeat (18) tick();
    idx = find_com();
    total++;
    if (idx < 0 || idx + 10 > ob_v.size()) begin
      bad++;
      $display("FAIL b2b_align: got com index %0d, expected a COM with 10 words after it", idx);
    end else begin
      for (int i = 0; i < 10; i++) begin
        total++;
        if (ob_v[idx+i] !== exp[i][10] || (exp[i][10] && ob_d[idx+i] !== exp[i][9:0])) begin
          bad++;
          $display("FAIL b2b_word_%0d: got v=%b d=%h, expected v=%b d=%h", i, ob_v[idx+i], ob_d[idx+i],
                   exp[i][10], exp[i][9:0]);
        end
      end
    end
    total++;
    if (n_add !== 2 || n_rem !== 0) begin
      bad++;
      $display("FAIL b2b_pulses: got add=%0d rem=%0d, expected 2 0", n_add, n_rem);
    end
    bus.fill_level = 5'd8;
  endtask

  task automatic test_boundary();
    // lo=6 and hi=10 themselves are inside the window.
    for (int f = 6; f <= 10; f += 4) begin
      bus.fill_level = 5'(f);
      clear_obs();
      src_q = '{COM_N, SKP_N, D1};
      repeat (10) tick();
      total++;
      if (n_add !== 0 || n_rem !== 0) begin
        bad++;
        $display("FAIL bound_fill_%0d: got add=%0d rem=%0d, expected 0 0", f, n_add, n_rem);
      end
    end
    bus.fill_level = 5'd8;
  endtask

  task automatic test_mode1();
    logic [10:0] exp [4];
    int idx;
    bus.buffer_mode = 1'b1;
    bus.fill_level  = 5'd0;
    clear_obs();
    src_q = '{COM_N, SKP_N, D1};
    repeat (10) tick();
    total++;
    if (n_add !== 0 || n_rem !== 0) begin
      bad++;
      $display("FAIL m1_empty: got add=%0d rem=%0d, expected 0 0", n_add, n_rem);
    end
    exp = '{{1'b1, COM_N}, {1'b0, 10'h0}, {1'b1, SKP_N}, {1'b1, D1}};
    bus.fill_level = 5'd5;
    clear_obs();
    src_q = '{COM_N, SKP_N, SKP_N, D1};
    repeat (12) tick();
    idx = find_com();
    total++;
    if (idx < 0 || idx + 4 > ob_v.size()) begin
      bad++;
      $display("FAIL m1_align: got com index %0d, expected a COM with 4 words after it", idx);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (ob_v[idx+i] !== exp[i][10] || (exp[i][10] && ob_d[idx+i] !== exp[i][9:0])) begin
          bad++;
          $display("FAIL m1_word_%0d: got v=%b d=%h, expected v=%b d=%h", i, ob_v[idx+i], ob_d[idx+i],
                   exp[i][10], exp[i][9:0]);
        end
      end
    end
    total++;
    if (n_add !== 0 || n_rem !== 1) begin
      bad++;
      $display("FAIL m1_pulses: got add=%0d rem=%0d, expected 0 1", n_add, n_rem);
    end
    bus.buffer_mode = 1'b0;
    bus.fill_level  = 5'd8;
    repeat (3) tick();
  endtask

  task automatic test_underflow();
    bus.underflow  = 1'b1;
    bus.fill_level = 5'd3;
    #1;
    total++;
    if (bus.read_enable !== 1'b0) begin
      bad++;
      $display("FAIL uf_re_cut: got re=%b, expected 0", bus.read_enable);
    end
    tick();
    bus.underflow = 1'b0;
    total++;
    if (bus.locked !== 1'b0 || bus.read_enable !== 1'b0 || bus.data_valid !== 1'b1) begin
      bad++;
      $display("FAIL uf_next: got locked=%b re=%b dv=%b, expected 0 0 1",
               bus.locked, bus.read_enable, bus.data_valid);
    end
    tick();
    total++;
    if (bus.data_valid !== 1'b0 || bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL uf_drain: got dv=%b locked=%b, expected 0 0", bus.data_valid, bus.locked);
    end
    tick();
    total++;
    if (bus.read_enable !== 1'b0) begin
      bad++;
      $display("FAIL uf_wait: got re=%b, expected 0", bus.read_enable);
    end
    bus.fill_level = 5'd8;
    tick();
    total++;
    if (bus.locked !== 1'b1 || bus.read_enable !== 1'b1) begin
      bad++;
      $display("FAIL uf_relock: got locked=%b re=%b, expected 1 1", bus.locked, bus.read_enable);
    end
    repeat (3) tick();
  endtask

  task automatic test_overflow();
    bus.overflow = 1'b1;
    tick();
    bus.overflow = 1'b0;
    total++;
    if (bus.overflow_err !== 1'b1 || bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got err=%b locked=%b, expected 1 1", bus.overflow_err, bus.locked);
    end
    repeat (4) tick();
    total++;
    if (bus.overflow_err !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: got err=%b, expected 1", bus.overflow_err);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.overflow_err !== 1'b0 || bus.locked !== 1'b0 || bus.data_valid !== 1'b0 ||
        bus.read_enable !== 1'b0) begin
      bad++;
      $display("FAIL ovf_reset: got err=%b locked=%b dv=%b re=%b, expected 0 0 0 0",
               bus.overflow_err, bus.locked, bus.data_valid, bus.read_enable);
    end
    #4 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_insert();
    test_remove();
    test_back_to_back();
    test_boundary();
    test_mode1();
    test_underflow();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
